// File: rtl/inputc_vcbuf_if.sv
// Link and switch-side signals of a router input channel.
// master: upstream link plus switch stage (drives flits and iready).
// slave:  the input channel buffer itself.
interface inputc_vcbuf_if #(
  parameter int unsigned VCN   = 2,
  parameter int unsigned VCW   = 1,
  parameter int unsigned DATAW = 35
) ();
  logic [DATAW-1:0] idata;
  logic             ivalid;
  logic [VCW-1:0]   ivch;
  logic [DATAW-1:0] odata;
  logic             ovalid;
  logic [VCW-1:0]   ovch;
  logic             iready;
  logic [VCN-1:0]   oack;
  logic [VCN-1:0]   olck;
  logic             oerr;

  modport master (
    output idata, ivalid, ivch, iready,
    input  odata, ovalid, ovch, oack, olck, oerr
  );

  modport slave (
    input  idata, ivalid, ivch, iready,
    output odata, ovalid, ovch, oack, olck, oerr
  );
endinterface

// File: rtl/inputc_vcbuf.sv
// Router input channel: one FIFO per virtual channel, round-robin head-of-line
// selection towards the switch, per-VC credit pulses and packet locks upstream.
module inputc_vcbuf #(
  parameter int unsigned ROUTERID = 0,
  parameter int unsigned PCHID    = 0,
  parameter int unsigned VCN      = 2,
  parameter int unsigned VCW      = 1,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned DATAW    = 35
) (
  input  logic           clk,
  input  logic           rst,
  inputc_vcbuf_if.slave  bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [DATAW-1:0] r_mem    [VCN][DEPTH];
  logic [PW-1:0]    r_rd_ptr [VCN];
  logic [PW-1:0]    r_wr_ptr [VCN];
  logic [CW-1:0]    r_count  [VCN];
  logic [VCW-1:0]   r_rr;
  logic [VCN-1:0]   r_oack;
  logic [VCN-1:0]   r_olck;
  logic             r_oerr;

  logic             w_any;
  logic [VCW-1:0]   w_win;
  logic             w_pop;
  logic [VCN-1:0]   w_pop_vec;
  logic [VCN-1:0]   w_wr_vec;
  logic             w_drop;
  logic             w_in_head;
  logic             w_out_tail;
  logic [DATAW-1:0] w_head_flit;

  // Flit type: bit DATAW-2 marks a head, bit DATAW-1 marks a tail.
  assign w_in_head  = bus.idata[DATAW-2];
  assign w_out_tail = w_head_flit[DATAW-1];

  function automatic logic [PW-1:0] f_ptr_next(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Round-robin pick: first non-empty VC scanning upward from r_rr with wrap.
  always_comb begin
    int idx;
    idx   = 0;
    w_any = 1'b0;
    w_win = '0;
    for (int i = 0; i < int'(VCN); i++) begin
      idx = (int'(r_rr) + i) % int'(VCN);
      if (!w_any && (r_count[idx] != '0)) begin
        w_any = 1'b1;
        w_win = VCW'(idx);
      end
    end
  end

  assign w_head_flit = w_any ? r_mem[w_win][r_rd_ptr[w_win]] : '0;
  assign w_pop       = w_any & bus.iready;

  // Per-VC write/pop decode; a full VC only accepts a write when it is popped too.
  always_comb begin
    w_pop_vec = '0;
    w_wr_vec  = '0;
    w_drop    = 1'b0;
    for (int v = 0; v < int'(VCN); v++) begin
      w_pop_vec[v] = w_pop && (w_win == VCW'(v));
      if (bus.ivalid && (bus.ivch == VCW'(v))) begin
        if ((r_count[v] != CW'(DEPTH)) || w_pop_vec[v]) begin
          w_wr_vec[v] = 1'b1;
        end else begin
          w_drop = 1'b1;
        end
      end
    end
  end

  // Flit storage; contents need no reset since counts gate visibility.
  always_ff @(posedge clk) begin
    for (int v = 0; v < int'(VCN); v++) begin
      if (w_wr_vec[v]) begin
        r_mem[v][r_wr_ptr[v]] <= bus.idata;
      end
    end
  end

  // Pointers, counts, round-robin pointer, credit pulses, locks and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < int'(VCN); v++) begin
        r_count[v]  <= '0;
        r_rd_ptr[v] <= '0;
        r_wr_ptr[v] <= '0;
      end
      r_rr   <= '0;
      r_oack <= '0;
      r_olck <= '0;
      r_oerr <= 1'b0;
    end else begin
      for (int v = 0; v < int'(VCN); v++) begin
        case ({w_wr_vec[v], w_pop_vec[v]})
          2'b10:   r_count[v] <= r_count[v] + CW'(1);
          2'b01:   r_count[v] <= r_count[v] - CW'(1);
          default: ;
        endcase
        if (w_wr_vec[v]) begin
          r_wr_ptr[v] <= f_ptr_next(r_wr_ptr[v]);
        end
        if (w_pop_vec[v]) begin
          r_rd_ptr[v] <= f_ptr_next(r_rd_ptr[v]);
        end
        // A head arriving outranks a tail leaving on the same edge.
        if (w_wr_vec[v] && w_in_head) begin
          r_olck[v] <= 1'b1;
        end else if (w_pop_vec[v] && w_out_tail) begin
          r_olck[v] <= 1'b0;
        end
      end
      r_oack <= w_pop_vec;
      if (w_pop) begin
        r_rr <= (w_win == VCW'(VCN - 1)) ? '0 : w_win + VCW'(1);
      end
      if (w_drop) begin
        r_oerr <= 1'b1;
      end
    end
  end

  assign bus.odata  = w_head_flit;
  assign bus.ovalid = w_any;
  assign bus.ovch   = w_win;
  assign bus.oack   = r_oack;
  assign bus.olck   = r_olck;
  assign bus.oerr   = r_oerr;

endmodule

// File: tb/tb_inputc_vcbuf.sv
// Directed bench for inputc_vcbuf: inputs change on the falling edge,
// outputs are checked on the falling edge after the rising edge acts.
module tb_inputc_vcbuf;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  inputc_vcbuf_if #(.VCN(2), .VCW(1), .DATAW(35)) u_if ();

  inputc_vcbuf #(
    .ROUTERID(0), .PCHID(0), .VCN(2), .VCW(1), .DEPTH(4), .DATAW(35)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] mk(logic [1:0] t, int p);
    return {t, 33'(p)};
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present inputs for one rising edge, return at the following falling edge.
  task automatic drive(logic v, logic ch, logic [34:0] d, logic rdy);
    u_if.ivalid = v;
    u_if.ivch   = ch;
    u_if.idata  = d;
    u_if.iready = rdy;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0);
    rst = 1'b0;
  endtask

  logic [34:0] exp_q [$];
  logic        exp_ch [$];

  initial begin
    clk    = 1'b0;
    rst    = 1'b1;
    n_chk  = 0;
    n_fail = 0;
    u_if.ivalid = 1'b0;
    u_if.ivch   = 1'b0;
    u_if.idata  = '0;
    u_if.iready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_odata", 64'(u_if.odata), 64'd0);
    check("rst_ovch", 64'(u_if.ovch), 64'd0);
    rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ovalid", 64'(u_if.ovalid), 64'd0);
      check("idle_oack", 64'(u_if.oack), 64'd0);
      check("idle_olck", 64'(u_if.olck), 64'd0);
      check("idle_oerr", 64'(u_if.oerr), 64'd0);
    end

    // 2: one packet through VC0 with iready high
    drive(1'b1, 1'b0, mk(2'b01, 'h100), 1'b1);
    check("pk_ovalid0", 64'(u_if.ovalid), 64'd1);
    check("pk_head", 64'(u_if.odata), 64'(mk(2'b01, 'h100)));
    check("pk_olck0", 64'(u_if.olck), 64'd1);
    check("pk_oack0", 64'(u_if.oack), 64'd0);
    drive(1'b1, 1'b0, mk(2'b00, 'h101), 1'b1);
    check("pk_body1", 64'(u_if.odata), 64'(mk(2'b00, 'h101)));
    check("pk_oack1", 64'(u_if.oack), 64'd1);
    drive(1'b1, 1'b0, mk(2'b00, 'h102), 1'b1);
    check("pk_body2", 64'(u_if.odata), 64'(mk(2'b00, 'h102)));
    check("pk_oack2", 64'(u_if.oack), 64'd1);
    drive(1'b1, 1'b0, mk(2'b10, 'h103), 1'b1);
    check("pk_tail", 64'(u_if.odata), 64'(mk(2'b10, 'h103)));
    check("pk_oack3", 64'(u_if.oack), 64'd1);
    check("pk_olck3", 64'(u_if.olck), 64'd1);
    drive(1'b0, 1'b0, '0, 1'b1);
    check("pk_ovalid4", 64'(u_if.ovalid), 64'd0);
    check("pk_oack4", 64'(u_if.oack), 64'd1);
    check("pk_olck4", 64'(u_if.olck), 64'd0);
    drive(1'b0, 1'b0, '0, 1'b0);
    check("pk_oack5", 64'(u_if.oack), 64'd0);

    // 3: round-robin alternation between two loaded VCs
    do_reset();
    drive(1'b1, 1'b0, mk(2'b00, 'hA0), 1'b0);
    drive(1'b1, 1'b1, mk(2'b00, 'hB0), 1'b0);
    drive(1'b1, 1'b0, mk(2'b00, 'hA1), 1'b0);
    drive(1'b1, 1'b1, mk(2'b00, 'hB1), 1'b0);
    exp_q  = '{mk(2'b00, 'hA0), mk(2'b00, 'hB0), mk(2'b00, 'hA1), mk(2'b00, 'hB1)};
    exp_ch = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      check("rr_ovch", 64'(u_if.ovch), 64'(exp_ch[i]));
      check("rr_odata", 64'(u_if.odata), 64'(exp_q[i]));
      drive(1'b0, 1'b0, '0, 1'b1);
    end
    check("rr_empty", 64'(u_if.ovalid), 64'd0);

    // 4: overflow of VC1 drops the fifth flit and sets the sticky error
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, mk(2'b00, 'hC0 + i), 1'b0);
    end
    check("ovf_oerr_pre", 64'(u_if.oerr), 64'd0);
    drive(1'b1, 1'b1, mk(2'b00, 'hC4), 1'b0);
    check("ovf_oerr_set", 64'(u_if.oerr), 64'd1);
    drive(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("ovf_ovch", 64'(u_if.ovch), 64'd1);
      check("ovf_odata", 64'(u_if.odata), 64'(mk(2'b00, 'hC0 + i)));
      drive(1'b0, 1'b0, '0, 1'b1);
    end
    check("ovf_empty", 64'(u_if.ovalid), 64'd0);
    check("ovf_oerr_sticky", 64'(u_if.oerr), 64'd1);

    // 5: write to a full VC0 in the same cycle it is popped
    do_reset();
    check("wp_oerr_rst", 64'(u_if.oerr), 64'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, mk(2'b00, 'hD0 + i), 1'b0);
    end
    check("wp_head", 64'(u_if.odata), 64'(mk(2'b00, 'hD0)));
    drive(1'b1, 1'b0, mk(2'b00, 'hEE), 1'b1);
    check("wp_oerr", 64'(u_if.oerr), 64'd0);
    exp_q = '{mk(2'b00, 'hD1), mk(2'b00, 'hD2), mk(2'b00, 'hD3), mk(2'b00, 'hEE)};
    for (int i = 0; i < 4; i++) begin
      check("wp_odata", 64'(u_if.odata), 64'(exp_q[i]));
      drive(1'b0, 1'b0, '0, 1'b1);
    end
    check("wp_empty", 64'(u_if.ovalid), 64'd0);
    check("wp_oerr_end", 64'(u_if.oerr), 64'd0);

    // 6: reset in the middle of a packet
    do_reset();
    drive(1'b1, 1'b0, mk(2'b01, 'h200), 1'b0);
    drive(1'b1, 1'b0, mk(2'b00, 'h201), 1'b0);
    drive(1'b1, 1'b0, mk(2'b00, 'h202), 1'b0);
    check("mr_olck_pre", 64'(u_if.olck), 64'd1);
    check("mr_ovalid_pre", 64'(u_if.ovalid), 64'd1);
    do_reset();
    check("mr_ovalid", 64'(u_if.ovalid), 64'd0);
    check("mr_olck", 64'(u_if.olck), 64'd0);
    check("mr_oack", 64'(u_if.oack), 64'd0);
    drive(1'b1, 1'b1, mk(2'b00, 'h300), 1'b0);
    check("mr_w_ovalid", 64'(u_if.ovalid), 64'd1);
    check("mr_w_ovch", 64'(u_if.ovch), 64'd1);
    check("mr_w_odata", 64'(u_if.odata), 64'(mk(2'b00, 'h300)));
    check("mr_w_olck", 64'(u_if.olck), 64'd0);
    drive(1'b1, 1'b0, mk(2'b01, 'h301), 1'b0);
    check("mr_h_olck", 64'(u_if.olck), 64'd1);
    check("mr_h_ovch", 64'(u_if.ovch), 64'd0);
    drive(1'b0, 1'b0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
